// File: rtl/icache_sa.sv
// Set-associative read-only instruction cache with tree-PLRU replacement, fence.i flush
// and saturating hit/miss counters. Lines are 256 bits; tag, valid and data live in flops.
module icache_sa #(
  parameter int unsigned NUM_WAYS = 4,
  parameter int unsigned NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  output logic [255:0] mem_rdata,
  output logic         mem_resp,
  input  logic         flush,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int unsigned Idx    = $clog2(NUM_SETS);
  localparam int unsigned Levels = $clog2(NUM_WAYS);
  localparam int unsigned WayW   = (NUM_WAYS > 1) ? Levels : 1;
  localparam int unsigned PlruW  = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;
  localparam int unsigned TagW   = 27 - Idx;

  typedef enum logic [1:0] {StIdle, StFill, StResp} state_e;

  state_e                           state_q, state_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0][PlruW-1:0]    plru_q, plru_d;
  logic                             pend_q, pend_d;
  logic [255:0]                     resp_q, resp_d;
  logic [31:0]                      hit_cnt_q, hit_cnt_d;
  logic [31:0]                      miss_cnt_q, miss_cnt_d;

  logic [TagW-1:0] tag_q  [NUM_SETS][NUM_WAYS];
  logic [255:0]    data_q [NUM_SETS][NUM_WAYS];

  logic [Idx-1:0]  idx;
  logic [TagW-1:0] tag;
  logic            hit;
  logic [WayW-1:0] hit_way;
  logic [WayW-1:0] victim;
  logic            has_invalid;
  logic            fill_we;
  logic            unused_offset;

  assign idx           = mem_address[4+Idx:5];
  assign tag           = mem_address[31:5+Idx];
  assign unused_offset = ^mem_address[4:0];

  // Heap-ordered tree: node n has children 2n+1 (left, lower ways) and 2n+2 (right).
  function automatic logic [PlruW-1:0] plru_touch(input logic [PlruW-1:0] cur,
                                                  input logic [WayW-1:0]  way);
    logic [PlruW-1:0] nxt;
    int unsigned      node;
    logic             b;
    nxt  = cur;
    node = 0;
    for (int unsigned lvl = 0; lvl < Levels; lvl++) begin
      b         = way[WayW-1-lvl];
      nxt[node] = ~b;
      node      = 2 * node + 1 + 32'(b);
    end
    return nxt;
  endfunction

  function automatic logic [WayW-1:0] plru_victim(input logic [PlruW-1:0] cur);
    logic [WayW-1:0] way;
    int unsigned     node;
    logic            b;
    way  = '0;
    node = 0;
    for (int unsigned lvl = 0; lvl < Levels; lvl++) begin
      b    = cur[node];
      way  = (way << 1) | WayW'(b);
      node = 2 * node + 1 + 32'(b);
    end
    return way;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WayW'(w);
      end
    end
  end

  always_comb begin
    has_invalid = 1'b0;
    victim      = plru_victim(plru_q[idx]);
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!has_invalid && !valid_q[idx][w]) begin
        has_invalid = 1'b1;
        victim      = WayW'(w);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    plru_d       = plru_q;
    pend_d       = pend_q;
    resp_d       = resp_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    fill_we      = 1'b0;
    mem_resp     = 1'b0;
    mem_rdata    = resp_q;
    pmem_read    = 1'b0;
    pmem_address = '0;
    case (state_q)
      StIdle: begin
        if (mem_read) begin
          if (hit) begin
            mem_resp    = 1'b1;
            mem_rdata   = data_q[idx][hit_way];
            plru_d[idx] = plru_touch(plru_q[idx], hit_way);
            if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
          end else begin
            if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
            state_d = StFill;
          end
        end
        // The lookup above already used the pre-flush arrays.
        if (flush) begin
          valid_d = '0;
          plru_d  = '0;
        end
      end
      StFill: begin
        pmem_read    = 1'b1;
        pmem_address = {mem_address[31:5], 5'b0};
        if (flush) pend_d = 1'b1;
        if (pmem_resp) begin
          fill_we             = 1'b1;
          valid_d[idx][victim] = 1'b1;
          plru_d[idx]         = plru_touch(plru_q[idx], victim);
          resp_d              = pmem_rdata;
          state_d             = StResp;
        end
      end
      StResp: begin
        mem_resp = 1'b1;
        state_d  = StIdle;
        if (flush || pend_q) begin
          valid_d = '0;
          plru_d  = '0;
          pend_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      plru_q     <= '0;
      pend_q     <= 1'b0;
      resp_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      plru_q     <= plru_d;
      pend_q     <= pend_d;
      resp_q     <= resp_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[idx][victim]  <= tag;
      data_q[idx][victim] <= pmem_rdata;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised set-associative, read-only instruction cache between the fetch stage and the instruction-side arbiter/physical memory. Generalises the direct-mapped instruction cache to NUM_WAYS ways and NUM_SETS sets, with tree-PLRU replacement, a single-cycle `flush` for `fence.i`, and saturating hit/miss counters. Line size stays 256 bits to match the memory bus.

## Interface
- NUM_WAYS, 4: associativity; power of two, 1..8.
- NUM_SETS, 8: sets; power of two, 2..64.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_address  in  32  fetch byte address.
- mem_read  in  1  fetch request; held with `mem_address` until `mem_resp`.
- mem_rdata  out  256  full line containing `mem_address`.
- mem_resp  out  1  one-cycle response strobe.
- flush  in  1  pulse; invalidate all lines.
- pmem_address  out  32  line-aligned fill address.
- pmem_read  out  1  fill request; held until `pmem_resp`.
- pmem_rdata  in  256  fill data, valid with `pmem_resp`.
- pmem_resp  in  1  fill complete.
- hit_count  out  32  saturating hit counter.
- miss_count  out  32  saturating miss counter.

## Operation
- Address split:
  - offset = [4:0], ignored.
  - index = [4+IDX:5], where IDX = log2(NUM_SETS).
  - tag = [31:5+IDX].
- Arrays: tag, valid and data are held in flops, per set and per way. PLRU holds NUM_WAYS-1 bits per set; no PLRU state when NUM_WAYS = 1.
- FSM states: IDLE, FILL, RESP.
- IDLE:
  - If `mem_read` is high, compare the tag across all valid ways of the indexed set.
  - Hit: drive `mem_resp`=1 combinationally with the hit way's line on `mem_rdata`. Update PLRU to point away from the hit way. Increment `hit_count`. Stay in IDLE.
  - Miss: increment `miss_count` once and go to FILL.
- FILL:
  - Drive `pmem_read`=1 with `pmem_address` = {`mem_address`[31:5], 5'b0}.
  - Victim is the lowest-index invalid way; if all ways are valid, use the PLRU victim.
  - On `pmem_resp`: write data and tag, set valid, update PLRU to point away from the victim, latch `pmem_rdata` into the response register, go to RESP.
- RESP: `mem_resp`=1 with `mem_rdata` taken from the response register; go to IDLE.
- No hit check in FILL or RESP. `mem_resp` never asserts in FILL.
- Flush:
  - In IDLE, clear every valid bit and reset PLRU on the next edge.
  - A request in that same cycle is evaluated against the pre-flush state.
  - A flush during FILL or RESP is recorded in a pending bit and applied on the cycle the FSM enters IDLE. The line just filled is also invalidated; the in-flight response still completes with the filled data.
- Counters saturate at 32'hFFFF_FFFF. They are never cleared by `flush`.
- Tree PLRU: bit=0 means the victim lies in the left (lower-index) subtree. On access, set each bit on the path to point to the opposite subtree.

## Timing
- Reset (asynchronous, `rst`=0):
  - State IDLE; all valid, PLRU and pending-flush bits 0; counters 0.
  - Outputs: `mem_resp`=0, `pmem_read`=0, `pmem_address`=0, `mem_rdata`=0 (response register cleared).
  - Data and tag arrays are not reset.
- Reset mid-FILL abandons the fill. `pmem_read` drops immediately, no array is written, and a later `pmem_resp` is ignored.
- Hit latency is 0 cycles: `mem_resp` is in the same cycle as `mem_read`.
- Miss latency is 1 cycle to `pmem_read`, then the memory latency, then 1 RESP cycle. `mem_resp` comes exactly one cycle after `pmem_resp`.
- `pmem_read` rises on the cycle after the miss is detected. It falls on the cycle after `pmem_resp`, i.e. it is low in RESP.
- `mem_read` must not drop before `mem_resp`. Behaviour if it does is undefined.
- `mem_rdata` is don't-care while `mem_resp`=0, except at reset.

## Test plan
- Cold miss then hit, with NUM_WAYS=4, NUM_SETS=8:
  - Read 0x0000_0040 and return line L with `pmem_resp` after 3 cycles.
  - Expect `mem_resp` 1 cycle later with data L; `miss_count`=1.
  - Re-read 0x0000_0044: same-cycle `mem_resp` with data L; `hit_count`=1.
- Associativity and PLRU:
  - Fill 5 lines mapping to set 0 (0x000, 0x100, 0x200, 0x300, 0x400).
  - Ways 0-3 fill in order. The 5th fill evicts way 0 (0x000).
  - After a re-hit of 0x100, the next miss evicts way 2 (0x200).
- Flush:
  - Fill 0x40, pulse `flush` in IDLE, re-read 0x40 -> miss with `pmem_read`=1.
  - Pulse `flush` during FILL -> the response still returns, and an immediate re-read misses.
- Reset mid-fill:
  - Assert `rst`=0 while `pmem_read`=1 -> `pmem_read` falls asynchronously.
  - After release, read the same address -> miss; `miss_count` restarts at 1.
- Counter saturation:
  - Force `hit_count`=32'hFFFF_FFFE and perform 3 hits -> `hit_count` holds at 32'hFFFF_FFFF.
- Direct-mapped corner, NUM_WAYS=1:
  - Alternate 0x000 and 0x100 (NUM_SETS=8) -> every access misses; 0 hits over 6 accesses.
